// File: rtl/mul8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// mul8_seq_ctrl : 8x8 multiply sequenced over a shared external 4x4 core.
// Optional macro MUL8_SIGNED_EN selects two's-complement operands.
// Revision : 1.0
// ============================================================================
module mul8_seq_ctrl #(
    parameter int FAST_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic [3:0]  core_a,
    output logic [3:0]  core_b,
    input  logic [7:0]  core_p
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_step;
    logic [15:0] r_acc;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_product;
    logic [3:0]  r_core_a;
    logic [3:0]  r_core_b;

    logic [7:0]  w_mag_a;
    logic [7:0]  w_mag_b;
    logic        w_fast;
    logic [15:0] w_pp;
    logic [15:0] w_sum;
    logic [15:0] w_res;

`ifdef MUL8_SIGNED_EN
    logic        r_sign;
    // Magnitude of -128 wraps to 0x80, which is still correct as unsigned.
    assign w_mag_a = a[7] ? (~a + 8'd1) : a;
    assign w_mag_b = b[7] ? (~b + 8'd1) : b;
    assign w_res   = r_sign ? (~w_sum + 16'd1) : w_sum;
`else
    assign w_mag_a = a;
    assign w_mag_b = b;
    assign w_res   = w_sum;
`endif

    assign w_fast = (FAST_ZERO != 0) && ((a == 8'd0) || (b == 8'd0));

    always_comb begin
        w_pp = 16'd0;
        case (r_step)
            2'd0:    w_pp = {8'd0, core_p};
            2'd1,
            2'd2:    w_pp = {4'd0, core_p, 4'd0};
            default: w_pp = {core_p, 8'd0};
        endcase
    end

    assign w_sum = r_acc + w_pp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_step    <= 2'd0;
            r_acc     <= 16'd0;
            r_a       <= 8'd0;
            r_b       <= 8'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= 16'd0;
            r_core_a  <= 4'd0;
            r_core_b  <= 4'd0;
`ifdef MUL8_SIGNED_EN
            r_sign    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_MUL: begin
                    r_acc  <= w_sum;
                    r_step <= r_step + 2'd1;
                    // Core operands are registered one step ahead of their use.
                    case (r_step)
                        2'd0: begin
                            r_core_a <= r_a[7:4];
                            r_core_b <= r_b[3:0];
                        end
                        2'd1: begin
                            r_core_a <= r_a[3:0];
                            r_core_b <= r_b[7:4];
                        end
                        2'd2: begin
                            r_core_a <= r_a[7:4];
                            r_core_b <= r_b[7:4];
                        end
                        default: begin
                            r_core_a  <= 4'd0;
                            r_core_b  <= 4'd0;
                            r_product <= w_res;
                            r_done    <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= S_DONE;
                        end
                    endcase
                end
                default: begin
                    if (start) begin
                        r_a    <= w_mag_a;
                        r_b    <= w_mag_b;
                        r_acc  <= 16'd0;
                        r_step <= 2'd0;
`ifdef MUL8_SIGNED_EN
                        r_sign <= a[7] ^ b[7];
`endif
                        if (w_fast) begin
                            r_product <= 16'd0;
                            r_done    <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= S_DONE;
                        end else begin
                            r_core_a <= w_mag_a[3:0];
                            r_core_b <= w_mag_b[3:0];
                            r_busy   <= 1'b1;
                            r_state  <= S_MUL;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;
    assign core_a  = r_core_a;
    assign core_b  = r_core_b;

endmodule
`default_nettype wire

// File: tb/tb_mul8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mul8_seq_ctrl : scoreboard bench for mul8_seq_ctrl (FAST_ZERO 1 and 0).
// Revision : 1.0
// ============================================================================
module tb_mul8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start_z;
    logic [7:0]  a, b, a_z, b_z;
    logic        busy, done, busy_z, done_z;
    logic [15:0] product, product_z;
    logic [3:0]  core_a, core_b, core_a_z, core_b_z;
    logic [7:0]  core_p, core_p_z;

    logic [15:0] q[$];
    logic [15:0] qz[$];
    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] ff_ca[4];
    logic [3:0] ff_cb[4];
    logic [3:0] t2_ca[4];
    logic [3:0] t2_cb[4];
    logic [15:0] ff_exp;

    always #5 clk = ~clk;

    // Stand-in for the parent-level 4x4 core.
    assign core_p   = core_a * core_b;
    assign core_p_z = core_a_z * core_b_z;

    mul8_seq_ctrl #(.FAST_ZERO(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product),
        .core_a(core_a), .core_b(core_b), .core_p(core_p)
    );

    mul8_seq_ctrl #(.FAST_ZERO(0)) u_dut_z (
        .clk(clk), .rst(rst), .start(start_z), .a(a_z), .b(b_z),
        .busy(busy_z), .done(done_z), .product(product_z),
        .core_a(core_a_z), .core_b(core_b_z), .core_p(core_p_z)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (q.size() == 0) chk("spurious_done", {31'd0, done}, 32'd0);
            else               chk("product", {16'd0, product}, {16'd0, q.pop_front()});
        end
        if (rst === 1'b0 && done_z === 1'b1) begin
            if (qz.size() == 0) chk("spurious_done_z", {31'd0, done_z}, 32'd0);
            else                chk("product_z", {16'd0, product_z}, {16'd0, qz.pop_front()});
        end
    end

    // Called on a negedge; returns on the negedge of MUL cycle 1.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [15:0] exp);
        start = 1'b1;
        a     = ia;
        b     = ib;
        q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && (q.size() != 0 || qz.size() != 0); i++) @(negedge clk);
        chk("drain_outstanding", q.size() + qz.size(), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
`ifdef MUL8_SIGNED_EN
        ff_ca  = '{4'h1, 4'h0, 4'h1, 4'h0};
        ff_cb  = '{4'h1, 4'h1, 4'h0, 4'h0};
        ff_exp = 16'h0001;
`else
        ff_ca  = '{4'hF, 4'hF, 4'hF, 4'hF};
        ff_cb  = '{4'hF, 4'hF, 4'hF, 4'hF};
        ff_exp = 16'hFE01;
`endif
        t2_ca = '{4'h2, 4'h1, 4'h2, 4'h1};
        t2_cb = '{4'h4, 4'h4, 4'h3, 4'h3};

        rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
        start_z = 1'b0; a_z = 8'd0; b_z = 8'd0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {7'd0, busy, done, product, core_a, core_b}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full-scale operands: timing of busy/done and core nibble sequence.
        issue(8'hFF, 8'hFF, ff_exp);
        for (int i = 0; i < 4; i++) begin
            chk("ff_busy_done", {30'd0, busy, done}, 32'd2);
            chk("ff_core", {24'd0, core_a, core_b}, {24'd0, ff_ca[i], ff_cb[i]});
            @(negedge clk);
        end
        chk("ff_done_cycle5", {30'd0, busy, done}, 32'd1);
        @(negedge clk);
        chk("ff_idle_cycle6", {22'd0, busy, done, core_a, core_b}, 32'd0);

        // Nibble ordering, then back-to-back start in the done cycle.
        issue(8'h12, 8'h34, 16'h03A8);
        for (int i = 0; i < 4; i++) begin
            chk("t2_core", {24'd0, core_a, core_b}, {24'd0, t2_ca[i], t2_cb[i]});
            @(negedge clk);
        end
        chk("t2_done", {31'd0, done}, 32'd1);
        issue(8'h0A, 8'h0B, 16'h006E);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        drain();

        // Fast-zero path versus full sequence.
        issue(8'h00, 8'h9C, 16'h0000);
        chk("fz_done_next", {30'd0, busy, done}, 32'd1);
        drain();
        issue(8'h55, 8'h00, 16'h0000);
        chk("fz_b_zero", {30'd0, busy, done}, 32'd1);
        drain();

        start_z = 1'b1; a_z = 8'h00; b_z = 8'h9C;
        qz.push_back(16'h0000);
        @(negedge clk);
        start_z = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("slow_zero_busy", {30'd0, busy_z, done_z}, 32'd2);
            @(negedge clk);
        end
        chk("slow_zero_done", {30'd0, busy_z, done_z}, 32'd1);
        drain();

        // Start while busy is ignored.
        issue(8'h10, 8'h10, 16'h0100);
        start = 1'b1; a = 8'hFF; b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        drain();
        chk("ignored_start_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-operation discards the result.
        start = 1'b1; a = 8'hAB; b = 8'hCD;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_reset", {7'd0, busy, done, product, core_a, core_b}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        issue(8'h03, 8'h05, 16'h000F);
        drain();

`ifdef MUL8_SIGNED_EN
        issue(8'h80, 8'h80, 16'h4000);
        drain();
        issue(8'hFD, 8'h05, 16'hFFF1);
        drain();
        issue(8'h7F, 8'h81, 16'hC0FF);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
